// File: rtl/leg_mem_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
package leg_mem_pkg;
  localparam int BUS_W = 32;

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} arb_state_t;

  typedef struct packed {
    logic             we;
    logic [3:0]       be;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } bus_cmd_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while a fetch is waiting.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Grants the single memory bus to fetch or data, data first, with a
// starvation bound that forces a fetch grant after STARVE_MAX data grants.
module mem_bus_arbiter
  import leg_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [BUS_W-1:0] if_addr,
  input  logic             if_flush,
  output logic             if_ready,
  output logic [BUS_W-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_be,
  input  logic [BUS_W-1:0] d_addr,
  input  logic [BUS_W-1:0] d_wdata,
  output logic             d_ready,
  output logic [BUS_W-1:0] d_rdata,
  output logic             bus_req,
  output logic             bus_we,
  output logic [3:0]       bus_be,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic [BUS_W-1:0] bus_rdata,
  input  logic             bus_ack,
  output logic             stall_f,
  output logic             stall_m
);
  arb_state_t state, nxt;
  bus_cmd_t   cmd_q;
  logic       flush_pend;
  logic       grant_d, grant_f;
  logic       sat;

  always_comb begin
    nxt     = state;
    grant_d = 1'b0;
    grant_f = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!sat || !if_req)) begin
          grant_d = 1'b1;
          nxt     = D_BUSY;
        end else if (if_req && !if_flush) begin
          grant_f = 1'b1;
          nxt     = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: if (bus_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Command is frozen at grant so the bus sees stable values until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cmd_q <= '0;
    else if (grant_d) cmd_q <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
    else if (grant_f) cmd_q <= '{we: 1'b0, be: 4'hF, addr: if_addr, wdata: '0};
  end

  // A flushed fetch still finishes on the bus; only its response is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 flush_pend <= 1'b0;
    else if (state != IF_BUSY)  flush_pend <= 1'b0;
    else if (bus_ack)           flush_pend <= 1'b0;
    else if (if_flush)          flush_pend <= 1'b1;
  end

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d && if_req),
    .clr   (grant_f || (state == IDLE && !if_req)),
    .sat   (sat)
  );

  assign bus_req   = (state != IDLE);
  assign bus_we    = cmd_q.we;
  assign bus_be    = cmd_q.be;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;

  assign d_ready  = (state == D_BUSY) && bus_ack;
  assign d_rdata  = bus_rdata;
  assign if_ready = (state == IF_BUSY) && bus_ack && !flush_pend && !if_flush;
  assign if_rdata = bus_rdata;

  assign stall_f = if_req && !if_ready;
  assign stall_m = d_req && !d_ready;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, contention, starvation, flush,
// reset mid-transaction and command stability.
module tb_mem_bus_arbiter;
  import leg_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, d_req, d_we, bus_ack;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_be;
  logic        if_ready, d_ready, bus_req, bus_we, stall_f, stall_m;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic ack_q = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  // bus_ack is a single-cycle pulse on this bus.
  always @(posedge clk) begin
    assert (!(bus_ack && ack_q)) else $error("bus_ack held for two cycles");
    ack_q <= bus_ack;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  arb_state_t exp_st  [6];
  int         exp_cnt [6];

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; bus_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; bus_rdata = 0; d_be = 0;
    repeat (3) step();
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    chk("rst_stall_f", 32'(stall_f), 0);
    chk("rst_stall_m", 32'(stall_m), 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_cnt", 32'(dut.u_starve.cnt), 0);
    step(); reset = 1'b1;

    // single fetch
    step(); if_req = 1; if_addr = 32'h100; #1;
    chk("f_idle_req", 32'(bus_req), 0);
    chk("f_idle_stall", 32'(stall_f), 1);
    step(); #1;
    chk("f_bus_req", 32'(bus_req), 1);
    chk("f_bus_addr", bus_addr, 32'h100);
    chk("f_bus_we", 32'(bus_we), 0);
    chk("f_bus_be", 32'(bus_be), 32'hF);
    step(); #1;
    chk("f_wait_ready", 32'(if_ready), 0);
    chk("f_wait_stall", 32'(stall_f), 1);
    step(); bus_ack = 1; bus_rdata = 32'hE3A01005; #1;
    chk("f_ready", 32'(if_ready), 1);
    chk("f_rdata", if_rdata, 32'hE3A01005);
    chk("f_stall_clr", 32'(stall_f), 0);
    step(); bus_ack = 0; if_req = 0; #1;
    chk("f_back_idle", 32'(bus_req), 0);

    // contention: store wins, fetch follows after one IDLE cycle
    step(); if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF; #1;
    chk("c_idle_req", 32'(bus_req), 0);
    step(); #1;
    chk("c_d_state", 32'(dut.state), 32'(D_BUSY));
    chk("c_bus_we", 32'(bus_we), 1);
    chk("c_bus_addr", bus_addr, 32'h2000);
    chk("c_bus_wdata", bus_wdata, 32'hDEADBEEF);
    chk("c_stall_m", 32'(stall_m), 1);
    step(); bus_ack = 1; #1;
    chk("c_d_ready", 32'(d_ready), 1);
    chk("c_if_ready", 32'(if_ready), 0);
    chk("c_stall_m_clr", 32'(stall_m), 0);
    step(); bus_ack = 0; d_req = 0; d_we = 0; #1;
    chk("c_gap_idle", 32'(bus_req), 0);
    step(); #1;
    chk("c_f_state", 32'(dut.state), 32'(IF_BUSY));
    chk("c_f_addr", bus_addr, 32'h104);
    chk("c_f_we", 32'(bus_we), 0);
    chk("c_cnt_clr", 32'(dut.u_starve.cnt), 0);
    step(); bus_ack = 1; bus_rdata = 32'h11112222; #1;
    chk("c_f_ready", 32'(if_ready), 1);
    step(); bus_ack = 0; if_req = 0;

    // starvation: D,D,D,D,F,D
    exp_st  = '{D_BUSY, D_BUSY, D_BUSY, D_BUSY, IF_BUSY, D_BUSY};
    exp_cnt = '{1, 2, 3, 4, 0, 1};
    step(); d_req = 1; d_we = 0; d_addr = 32'h3000; if_req = 1; if_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk($sformatf("s_state%0d", i), 32'(dut.state), 32'(exp_st[i]));
      chk($sformatf("s_cnt%0d", i), 32'(dut.u_starve.cnt), 32'(exp_cnt[i]));
      step(); bus_ack = 1; bus_rdata = 32'(i); #1;
      if (exp_st[i] == D_BUSY) chk($sformatf("s_dr%0d", i), 32'(d_ready), 1);
      else                     chk($sformatf("s_fr%0d", i), 32'(if_ready), 1);
      step(); bus_ack = 0;
      if (exp_st[i] == D_BUSY) d_addr = d_addr + 4;
      if (i == 5) begin d_req = 0; if_req = 0; end
      #1;
      chk($sformatf("s_gap%0d", i), 32'(bus_req), 0);
    end

    // flush during fetch
    step(); if_req = 1; if_addr = 32'h300;
    step();
    step(); if_flush = 1; #1;
    chk("fl_ready_c2", 32'(if_ready), 0);
    step(); if_flush = 0; if_addr = 32'h40; #1;
    chk("fl_pend", 32'(dut.flush_pend), 1);
    step(); bus_ack = 1; bus_rdata = 32'h12345678; #1;
    chk("fl_ready_ack", 32'(if_ready), 0);
    chk("fl_addr_hold", bus_addr, 32'h300);
    step(); bus_ack = 0; #1;
    chk("fl_idle", 32'(bus_req), 0);
    chk("fl_pend_clr", 32'(dut.flush_pend), 0);
    step(); #1;
    chk("fl_next_state", 32'(dut.state), 32'(IF_BUSY));
    chk("fl_next_addr", bus_addr, 32'h40);
    step(); bus_ack = 1; bus_rdata = 32'hCAFEF00D; #1;
    chk("fl_next_ready", 32'(if_ready), 1);
    chk("fl_next_rdata", if_rdata, 32'hCAFEF00D);
    step(); bus_ack = 0; if_req = 0;

    // command stability while waiting for ack
    step(); d_req = 1; d_we = 1; d_addr = 32'h5000; d_wdata = 32'hA5A50001; d_be = 4'h3;
    step(); d_addr = 32'h6000; d_wdata = 32'h0; d_be = 4'hC;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("st_addr%0d", k), bus_addr, 32'h5000);
      chk($sformatf("st_wdata%0d", k), bus_wdata, 32'hA5A50001);
      chk($sformatf("st_be%0d", k), 32'(bus_be), 32'h3);
      chk($sformatf("st_dr%0d", k), 32'(d_ready), 0);
      step();
    end
    bus_ack = 1; #1;
    chk("st_ready", 32'(d_ready), 1);
    chk("st_addr_ack", bus_addr, 32'h5000);
    step(); bus_ack = 0; d_req = 0; d_we = 0;

    // reset in D_BUSY, stray ack afterwards
    step(); d_req = 1; d_addr = 32'h7000; if_req = 1; if_addr = 32'h400;
    step(); #1;
    chk("r_busy", 32'(bus_req), 1);
    chk("r_cnt_pre", 32'(dut.u_starve.cnt), 1);
    #2 reset = 0; #1;
    chk("r_bus_drop", 32'(bus_req), 0);
    chk("r_state", 32'(dut.state), 32'(IDLE));
    chk("r_cnt", 32'(dut.u_starve.cnt), 0);
    chk("r_d_ready", 32'(d_ready), 0);
    d_req = 0; if_req = 0;
    step(); step(); reset = 1;
    step(); bus_ack = 1; #1;
    chk("r_stray_dr", 32'(d_ready), 0);
    chk("r_stray_ir", 32'(if_ready), 0);
    step(); bus_ack = 0; #1;
    chk("r_stray_state", 32'(dut.state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
